// File: rtl/sync_debounce_pkg.sv
// sync_debounce_pkg: shared constants and counter-width helper for sync_debounce
package sync_debounce_pkg;
  localparam int DEFAULT_MAX_COUNT = 500000;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int EVENT_CNT_W = 16;
  function automatic int cnt_width(input int max);
    return $clog2(max + 1);
  endfunction
endpackage

// File: rtl/sync_debounce_sync_chain.sv
// sync_chain: plain flop shift register bringing an asynchronous bit into the clock domain
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: synchroniser + counter debouncer with change/rise/fall pulses
// Optional event_cnt output when SYNC_DEBOUNCE_EVENT_CNT_EN is defined.
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int max_count = DEFAULT_MAX_COUNT,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in,
  output logic out,
  output logic edj,
  output logic rise,
  output logic fall
`ifdef SYNC_DEBOUNCE_EVENT_CNT_EN
  ,
  output logic [EVENT_CNT_W-1:0] event_cnt
`endif
);
  localparam int CW = cnt_width(max_count);
  localparam logic [CW-1:0] LAST = CW'(max_count - 1);
  logic s;
  logic hit;
  logic [CW-1:0] cnt;
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clock(clock),
    .reset_n(reset_n),
    .d(in),
    .q(s)
  );
  // The counter never passes LAST, so equality is the whole qualification test.
  assign hit = (s != out) && (cnt == LAST);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      out <= 1'b0;
      edj <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      cnt <= (s == out || hit) ? '0 : cnt + CW'(1);
      out <= hit ? s : out;
      edj <= hit;
      rise <= hit & s;
      fall <= hit & ~s;
    end
`ifdef SYNC_DEBOUNCE_EVENT_CNT_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) event_cnt <= '0;
    else event_cnt <= event_cnt + EVENT_CNT_W'(edj);
`endif
endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: scoreboard bench for sync_debounce (max_count=4, SYNC_STAGES=2)
module tb_sync_debounce;
  import sync_debounce_pkg::*;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic din = 1'b1;
  logic out, edj, rise, fall;
`ifdef SYNC_DEBOUNCE_EVENT_CNT_EN
  logic [EVENT_CNT_W-1:0] event_cnt;
`endif
  typedef struct {
    logic up;
    int cyc;
  } ev_t;
  ev_t exp_q[$];
  ev_t e;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  sync_debounce #(.max_count(4), .SYNC_STAGES(2)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .in(din),
    .out(out),
    .edj(edj),
    .rise(rise),
    .fall(fall)
`ifdef SYNC_DEBOUNCE_EVENT_CNT_EN
    ,
    .event_cnt(event_cnt)
`endif
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic expect_ev(input logic up, input int lat);
    exp_q.push_back('{up, cyc + lat});
  endtask
  task automatic level(input string name, input logic v);
    @(negedge clock);
    check(name, out, v);
  endtask
  // Every pulse must match the oldest expected event in time, direction and new level.
  always @(negedge clock)
    if (edj | rise | fall) begin
      check("pulse_or", edj, rise | fall);
      check("pulse_excl", rise & fall, 0);
      if (exp_q.size() == 0) check("unexpected_pulse", edj, 0);
      else begin
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_dir", rise, e.up);
        check("pulse_out", out, e.up);
      end
    end
  initial begin
    repeat (4) begin
      @(negedge clock);
      check("rst_out", out, 0);
      check("rst_pulse", edj | rise | fall, 0);
    end
    tick(1);
    reset_n = 1'b1;
    expect_ev(1'b1, 6);
    tick(10);
    level("release_out", 1'b1);
    tick(1);
    din = 1'b0;
    expect_ev(1'b0, 6);
    tick(10);
    level("fall_out", 1'b0);
    tick(1);
    repeat (3) begin
      din = 1'b1;
      tick(2);
      din = 1'b0;
      tick(3);
    end
    tick(6);
    level("bounce_out", 1'b0);
    tick(1);
    din = 1'b1;
    expect_ev(1'b1, 6);
    expect_ev(1'b0, 10);
    tick(4);
    din = 1'b0;
    tick(10);
    level("thresh4_out", 1'b0);
    tick(1);
    din = 1'b1;
    tick(3);
    din = 1'b0;
    tick(8);
    level("thresh3_out", 1'b0);
    tick(1);
    din = 1'b1;
    tick(3);
    #2 reset_n = 1'b0;
    #1 check("midrst_out", out, 0);
    check("midrst_pulse", edj | rise | fall, 0);
    tick(1);
    reset_n = 1'b1;
    expect_ev(1'b1, 6);
    tick(10);
    level("midrst_release_out", 1'b1);
`ifdef SYNC_DEBOUNCE_EVENT_CNT_EN
    tick(1);
    din = 1'b0;
    expect_ev(1'b0, 6);
    tick(10);
    reset_n = 1'b0;
    #1 check("evt_rst", event_cnt, 0);
    tick(1);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = ~din;
      expect_ev(din, 6);
      tick(10);
    end
    check("evt_three", event_cnt, 3);
    @(negedge clock);
    force dut.event_cnt = 16'hFFFF;
    #1 release dut.event_cnt;
    tick(1);
    check("evt_preload", event_cnt, 16'hFFFF);
    din = 1'b0;
    expect_ev(1'b0, 6);
    tick(10);
    check("evt_wrap", event_cnt, 0);
`endif
    tick(5);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
